// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_pkg
//  Description : Shared types and constants for the five-stage ARM core
//                pipeline control: controller FSM states, NZCV bit indices
//                and register-index width.
//  Revision    : 1.0  initial release
// ============================================================================
package arm_pkg;

    // Register-file index width (r0..r15)
    localparam int c_reg_idx_w = 4;

    // NZCV bit positions inside the status register
    localparam int c_flag_n = 3;
    localparam int c_flag_z = 2;
    localparam int c_flag_c = 1;
    localparam int c_flag_v = 0;

    // Memory-handshake supervisor states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } ctrl_state_e;

endpackage : arm_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational RAW hazard check between the ID-stage source
//                registers and the destinations of EXE (and, without a
//                forwarding unit, MEM). With forwarding only a load in EXE
//                can cause a stall.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_detect
    import arm_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic                   id_valid,
    input  logic [c_reg_idx_w-1:0] id_src1,
    input  logic [c_reg_idx_w-1:0] id_src2,
    input  logic                   id_two_src,
    input  logic                   exe_valid,
    input  logic [c_reg_idx_w-1:0] exe_dest,
    input  logic                   exe_wb_en,
    input  logic                   exe_mem_r_en,
    input  logic [c_reg_idx_w-1:0] mem_dest,
    input  logic                   mem_wb_en,
    output logic                   hazard
);

    logic w_match1;
    logic w_match2;

    if (FWD_EN != 0) begin : g_fwd
        // Forwarding covers ALU results; only a load's data arrives too late
        logic w_exe_load;
        logic w_unused_mem;
        assign w_exe_load   = exe_valid & exe_wb_en & exe_mem_r_en;
        assign w_match1     = w_exe_load & (exe_dest == id_src1);
        assign w_match2     = w_exe_load & (exe_dest == id_src2);
        assign w_unused_mem = ^{mem_dest, mem_wb_en};
    end else begin : g_no_fwd
        // No bypass paths: any pending write-back in EXE or MEM must drain
        logic w_exe_wr;
        logic w_unused_ld;
        assign w_exe_wr    = exe_valid & exe_wb_en;
        assign w_match1    = (w_exe_wr  & (exe_dest == id_src1)) |
                             (mem_wb_en & (mem_dest == id_src1));
        assign w_match2    = (w_exe_wr  & (exe_dest == id_src2)) |
                             (mem_wb_en & (mem_dest == id_src2));
        assign w_unused_ld = exe_mem_r_en;
    end

    assign hazard = id_valid & (w_match1 | (id_two_src & w_match2));

endmodule : hazard_detect
`default_nettype wire

// File: rtl/exe_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : exe_pipeline_ctrl
//  Description : Central pipeline controller beside the EXE stage. Holds the
//                NZCV register, arbitrates stall / branch flush / hazard
//                bubble for IF/ID/EXE, supervises the memory wait handshake
//                with a timeout, and keeps saturating stall/flush counters.
//  Revision    : 1.0  initial release
// ============================================================================
module exe_pipeline_ctrl
    import arm_pkg::*;
#(
    parameter int FWD_EN  = 1,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [c_reg_idx_w-1:0] id_src1,
    input  logic [c_reg_idx_w-1:0] id_src2,
    input  logic                   id_two_src,
    input  logic                   exe_valid,
    input  logic [c_reg_idx_w-1:0] exe_dest,
    input  logic                   exe_wb_en,
    input  logic                   exe_mem_r_en,
    input  logic                   exe_s,
    input  logic [3:0]             exe_status,
    input  logic                   exe_branch_taken,
    input  logic [c_reg_idx_w-1:0] mem_dest,
    input  logic                   mem_wb_en,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic [3:0]             status_reg,
    output logic                   freeze_if,
    output logic                   freeze_id,
    output logic                   bubble_exe,
    output logic                   flush_if_id,
    output logic                   stall_all,
    output logic                   mem_err,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    ctrl_state_e      r_state;
    ctrl_state_e      w_state_nxt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_nxt;
    logic             r_mem_err;
    logic [3:0]       r_status;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_hazard;
    logic w_stall_all;
    logic w_br;
    logic w_freeze;
    logic w_bubble;

    hazard_detect #(
        .FWD_EN (FWD_EN)
    ) u_hazard_detect (
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_valid    (exe_valid),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .hazard       (w_hazard)
    );

    // FSM state and wait counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next-state logic and raw stall; a ready in the timeout cycle completes
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_stall_all    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    w_stall_all    = 1'b1;
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = 8'd0;
                end else begin
                    w_stall_all = 1'b1;
                    if (r_wait_cnt == c_timeout) begin
                        w_state_nxt = ST_ERROR;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    end
                end
            end
            ST_ERROR: begin
                w_stall_all = 1'b1;
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Priority arbitration: global stall, then taken branch, then hazard
    always_comb begin
        w_br     = exe_valid & exe_branch_taken & ~w_stall_all;
        w_freeze = 1'b0;
        w_bubble = 1'b0;
        if (w_stall_all) begin
            w_freeze = 1'b1;
        end else if (w_br) begin
            w_bubble = 1'b1;
        end else if (w_hazard) begin
            w_freeze = 1'b1;
            w_bubble = 1'b1;
        end
    end

    // Control outputs are held low while reset is asserted
    assign freeze_if   = rst & w_freeze;
    assign freeze_id   = rst & w_freeze;
    assign bubble_exe  = rst & w_bubble;
    assign flush_if_id = rst & w_br;
    assign stall_all   = rst & w_stall_all;

    // Sticky timeout error, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_err <= 1'b0;
        end else if (w_state_nxt == ST_ERROR) begin
            r_mem_err <= 1'b1;
        end
    end

    // NZCV register; a stalled flag-setting instruction does not commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status <= 4'd0;
        end else if (exe_valid && exe_s && !w_stall_all) begin
            r_status <= exe_status;
        end
    end

    // Saturating performance counters for freeze cycles and branch flushes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_freeze && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_br && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign mem_err    = r_mem_err;
    assign status_reg = r_status;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule : exe_pipeline_ctrl
`default_nettype wire

// File: tb/tb_exe_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exe_pipeline_ctrl
//  Description : Self-checking bench for exe_pipeline_ctrl (FWD_EN=1,
//                TIMEOUT=4) with directed scenarios and randomized traffic
//                compared against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exe_pipeline_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_two_src;
    logic [3:0]       id_src1, id_src2;
    logic             exe_valid, exe_wb_en, exe_mem_r_en, exe_s, exe_branch_taken;
    logic [3:0]       exe_dest, exe_status, mem_dest;
    logic             mem_wb_en, mem_req, mem_ready;
    logic [3:0]       status_reg;
    logic             freeze_if, freeze_id, bubble_exe, flush_if_id, stall_all, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    bit       m_waiting;
    int       m_wait;
    bit       m_err;
    bit [3:0] m_status;
    int       m_stall_cnt, m_flush_cnt;
    bit       e_stall, e_freeze, e_bubble, e_flush;

    exe_pipeline_ctrl #(
        .FWD_EN  (1),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_src1          (id_src1),
        .id_src2          (id_src2),
        .id_two_src       (id_two_src),
        .exe_valid        (exe_valid),
        .exe_dest         (exe_dest),
        .exe_wb_en        (exe_wb_en),
        .exe_mem_r_en     (exe_mem_r_en),
        .exe_s            (exe_s),
        .exe_status       (exe_status),
        .exe_branch_taken (exe_branch_taken),
        .mem_dest         (mem_dest),
        .mem_wb_en        (mem_wb_en),
        .mem_req          (mem_req),
        .mem_ready        (mem_ready),
        .status_reg       (status_reg),
        .freeze_if        (freeze_if),
        .freeze_id        (freeze_id),
        .bubble_exe       (bubble_exe),
        .flush_if_id      (flush_if_id),
        .stall_all        (stall_all),
        .mem_err          (mem_err),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    always #5 clk = ~clk;

    // A register read in ID is unsafe only if the EXE instruction loads it
    function automatic bit loaded_by_exe(input logic [3:0] r);
        return exe_valid && exe_wb_en && exe_mem_r_en && (exe_dest == r);
    endfunction

    // Expected control outputs for the current inputs and model state
    function automatic void model_eval();
        bit haz;
        if (m_err)          e_stall = 1'b1;
        else if (m_waiting) e_stall = !mem_ready;
        else                e_stall = mem_req && !mem_ready;
        haz      = id_valid && (loaded_by_exe(id_src1) || (id_two_src && loaded_by_exe(id_src2)));
        e_flush  = exe_valid && exe_branch_taken && !e_stall;
        e_bubble = !e_stall && (e_flush || haz);
        e_freeze = e_stall || (!e_flush && haz);
    endfunction

    function automatic void model_reset();
        m_waiting = 0; m_wait = 0; m_err = 0; m_status = 4'd0;
        m_stall_cnt = 0; m_flush_cnt = 0;
    endfunction

    // Advance the model by one clock using the inputs present at the edge
    function automatic void model_commit();
        model_eval();
        if (exe_valid && exe_s && !e_stall) m_status = exe_status;
        if (e_freeze && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (e_flush && m_flush_cnt < CNT_MAX) m_flush_cnt++;
        if (m_err) begin
        end else if (m_waiting) begin
            if (mem_ready)               m_waiting = 0;
            else if (m_wait == TIMEOUT)  m_err = 1;
            else                         m_wait++;
        end else if (mem_req && !mem_ready) begin
            m_waiting = 1;
            m_wait    = 1;
        end
    endfunction

    task automatic idle_inputs();
        id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
        exe_valid = 0; exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
        exe_s = 0; exe_status = 0; exe_branch_taken = 0;
        mem_dest = 0; mem_wb_en = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        mem_req = 1; exe_valid = 1; exe_branch_taken = 1;
        id_valid = 1; exe_wb_en = 1; exe_mem_r_en = 1;
        rst = 1'b0;
        model_reset();
        #3;
        n_checks++;
        if ({freeze_if, freeze_id, bubble_exe, flush_if_id, stall_all} !== 5'b00000)
            $display("FAIL reset_ctrl: got %b want 00000", {freeze_if, freeze_id, bubble_exe, flush_if_id, stall_all});
        else n_pass++;
        n_checks++;
        if ({status_reg, mem_err, stall_cnt, flush_cnt} !== '0)
            $display("FAIL reset_regs: status=%h err=%b stall_cnt=%0d flush_cnt=%0d want all 0", status_reg, mem_err, stall_cnt, flush_cnt);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        exe_valid = 1; exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 4'd3;
        id_valid = 1; id_src1 = 4'd3; id_src2 = 4'd7; id_two_src = 1;
        @(negedge clk);
        n_checks++;
        if ({freeze_if, freeze_id, bubble_exe, flush_if_id, stall_all} !== 5'b11100)
            $display("FAIL load_use_ctrl: got %b want 11100", {freeze_if, freeze_id, bubble_exe, flush_if_id, stall_all});
        else n_pass++;
        tick();
        exe_valid = 0;
        @(negedge clk);
        n_checks++;
        if ({freeze_if, freeze_id, bubble_exe} !== 3'b000)
            $display("FAIL load_use_release: got %b want 000", {freeze_if, freeze_id, bubble_exe});
        else n_pass++;
        n_checks++;
        if (stall_cnt !== 16'd1)
            $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_branch_vs_hazard();
        do_reset();
        exe_valid = 1; exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 4'd5;
        exe_branch_taken = 1; id_valid = 1; id_src1 = 4'd0; id_src2 = 4'd5; id_two_src = 1;
        @(negedge clk);
        n_checks++;
        if ({freeze_if, freeze_id, bubble_exe, flush_if_id, stall_all} !== 5'b00110)
            $display("FAIL branch_hazard_ctrl: got %b want 00110", {freeze_if, freeze_id, bubble_exe, flush_if_id, stall_all});
        else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if ({flush_cnt, stall_cnt} !== {16'd1, 16'd0})
            $display("FAIL branch_counts: flush_cnt=%0d stall_cnt=%0d want 1 0", flush_cnt, stall_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        exe_valid = 1; exe_branch_taken = 1; mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({freeze_if, freeze_id, bubble_exe, flush_if_id, stall_all} !== 5'b11001)
                $display("FAIL mem_wait_stall[%0d]: got %b want 11001", i, {freeze_if, freeze_id, bubble_exe, flush_if_id, stall_all});
            else n_pass++;
            tick();
        end
        mem_ready = 1;
        @(negedge clk);
        n_checks++;
        if ({freeze_if, freeze_id, bubble_exe, flush_if_id, stall_all} !== 5'b00110)
            $display("FAIL mem_wait_ready: got %b want 00110", {freeze_if, freeze_id, bubble_exe, flush_if_id, stall_all});
        else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if ({stall_all, stall_cnt, flush_cnt} !== {1'b0, 16'd3, 16'd1})
            $display("FAIL mem_wait_after: stall=%b stall_cnt=%0d flush_cnt=%0d want 0 3 1", stall_all, stall_cnt, flush_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i <= TIMEOUT; i++) begin
            @(negedge clk);
            n_checks++;
            if ({stall_all, mem_err} !== 2'b10)
                $display("FAIL timeout_wait[%0d]: stall,err=%b want 10", i, {stall_all, mem_err});
            else n_pass++;
            tick();
        end
        mem_req = 0; mem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({stall_all, mem_err} !== 2'b11)
                $display("FAIL timeout_error[%0d]: stall,err=%b want 11", i, {stall_all, mem_err});
            else n_pass++;
            tick();
        end
        // Ready in the final allowed cycle completes without error
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < TIMEOUT; i++) tick();
        mem_ready = 1;
        @(negedge clk);
        n_checks++;
        if (stall_all !== 1'b0)
            $display("FAIL timeout_boundary_ready: stall=%b want 0", stall_all);
        else n_pass++;
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if ({stall_all, mem_err} !== 2'b00)
            $display("FAIL timeout_boundary_after: stall,err=%b want 00", {stall_all, mem_err});
        else n_pass++;
        tick();
    endtask

    task automatic test_flags();
        do_reset();
        exe_valid = 1; exe_s = 1; exe_status = 4'b1010;
        tick();
        @(negedge clk);
        n_checks++;
        if (status_reg !== 4'b1010)
            $display("FAIL flags_update: got %b want 1010", status_reg);
        else n_pass++;
        exe_status = 4'b0101; mem_req = 1; mem_ready = 0;
        tick();
        @(negedge clk);
        n_checks++;
        if (status_reg !== 4'b1010)
            $display("FAIL flags_stalled: got %b want 1010", status_reg);
        else n_pass++;
        idle_inputs();
        mem_ready = 1;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        exe_valid = 1; exe_s = 1; exe_status = 4'b0110;
        exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 4'd2; id_valid = 1; id_src1 = 4'd2;
        tick();
        exe_s = 0; mem_req = 1; mem_ready = 0;
        tick();
        tick();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({freeze_if, freeze_id, bubble_exe, flush_if_id, stall_all} !== 5'b00000)
            $display("FAIL async_reset_ctrl: got %b want 00000", {freeze_if, freeze_id, bubble_exe, flush_if_id, stall_all});
        else n_pass++;
        n_checks++;
        if ({status_reg, mem_err, stall_cnt, flush_cnt} !== '0)
            $display("FAIL async_reset_regs: status=%h err=%b stall_cnt=%0d flush_cnt=%0d want all 0", status_reg, mem_err, stall_cnt, flush_cnt);
        else n_pass++;
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if (stall_all !== 1'b0)
            $display("FAIL async_reset_run: stall=%b want 0", stall_all);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc % 50 == 0) do_reset();
            id_valid         = ($urandom_range(0, 3) != 0);
            id_src1          = 4'($urandom_range(0, 3));
            id_src2          = 4'($urandom_range(0, 3));
            id_two_src       = 1'($urandom);
            exe_valid        = ($urandom_range(0, 3) != 0);
            exe_dest         = 4'($urandom_range(0, 3));
            exe_wb_en        = 1'($urandom);
            exe_mem_r_en     = 1'($urandom);
            exe_s            = 1'($urandom);
            exe_status       = 4'($urandom);
            exe_branch_taken = ($urandom_range(0, 4) == 0);
            mem_dest         = 4'($urandom_range(0, 3));
            mem_wb_en        = 1'($urandom);
            mem_req          = ($urandom_range(0, 2) == 0);
            mem_ready        = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            model_eval();
            n_checks++;
            if ({freeze_if, freeze_id, bubble_exe, flush_if_id, stall_all} !==
                {e_freeze, e_freeze, e_bubble, e_flush, e_stall})
                $display("FAIL random_ctrl[%0d]: got %b want %b", cyc,
                         {freeze_if, freeze_id, bubble_exe, flush_if_id, stall_all},
                         {e_freeze, e_freeze, e_bubble, e_flush, e_stall});
            else n_pass++;
            n_checks++;
            if ({status_reg, mem_err, stall_cnt, flush_cnt} !==
                {m_status, m_err, CNT_W'(m_stall_cnt), CNT_W'(m_flush_cnt)})
                $display("FAIL random_regs[%0d]: status=%h err=%b stall_cnt=%0d flush_cnt=%0d want %h %b %0d %0d",
                         cyc, status_reg, mem_err, stall_cnt, flush_cnt, m_status, m_err, m_stall_cnt, m_flush_cnt);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_vs_hazard();
        test_mem_wait();
        test_timeout();
        test_flags();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_exe_pipeline_ctrl
`default_nettype wire

// File: doc/exe_pipeline_ctrl.md
# exe_pipeline_ctrl

Central pipeline controller for the five-stage ARM core, sitting beside the EXE stage. It owns the NZCV status register and the load-use hazard check, and it sequences freezes, bubbles and branch flushes across IF/ID/EXE. It also supervises the memory-stage wait handshake with a timeout and keeps stall and flush performance counters.

## Interface
Parameters:
- FWD_EN, 1, forwarding unit present; 1 = only load-use hazards stall, 0 = any EXE/MEM write-back match stalls
- TIMEOUT, 255, maximum MEM_WAIT cycles before error (1..255)
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_src1, id_src2  in  4  ID source registers
- id_two_src  in  1  id_src2 is read
- exe_valid  in  1  EXE holds a real instruction
- exe_dest  in  4  EXE destination
- exe_wb_en, exe_mem_r_en  in  1  EXE write-back / load
- exe_s  in  1  EXE instruction updates flags
- exe_status  in  4  NZCV produced by ALU
- exe_branch_taken  in  1  EXE branch resolved taken
- mem_dest  in  4  MEM destination
- mem_wb_en  in  1  MEM write-back
- mem_req  in  1  MEM stage memory access pending
- mem_ready  in  1  memory completes access this cycle
- status_reg  out  4  architectural NZCV, fed to EXE carry-in
- freeze_if, freeze_id  out  1  hold PC / IF-ID register
- bubble_exe  out  1  load NOP into ID/EXE register
- flush_if_id  out  1  clear IF/ID register
- stall_all  out  1  freeze EXE/MEM/WB registers
- mem_err  out  1  sticky memory timeout
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- FSM states: RUN, MEM_WAIT, ERROR; reset to RUN.
- RUN: if mem_req & !mem_ready, go to MEM_WAIT with wait_cnt=1. Otherwise stay in RUN.
- MEM_WAIT: stall_all=1 while !mem_ready, and wait_cnt increments. When mem_ready=1: stall_all=0 in that cycle and return to RUN. If wait_cnt==TIMEOUT and !mem_ready, go to ERROR.
- ERROR: stall_all=1, mem_err=1. The only exit is reset.
- RUN stall_all = mem_req & !mem_ready, so the first wait cycle already stalls.
- hazard (combinational): id_valid & ((src1 match) | (id_two_src & src2 match)).
  - FWD_EN=1: match means exe_valid & exe_wb_en & exe_mem_r_en & exe_dest==src.
  - FWD_EN=0: match means (exe_valid & exe_wb_en & exe_dest==src) | (mem_wb_en & mem_dest==src).
- br = exe_valid & exe_branch_taken & !stall_all.
- Priority, highest first:
  1. stall_all: freeze_if=freeze_id=1, bubble_exe=0, flush_if_id=0.
  2. br: flush_if_id=1, bubble_exe=1, freezes 0.
  3. hazard: freeze_if=freeze_id=1, bubble_exe=1.
- status_reg <= exe_status when exe_valid & exe_s & !stall_all.
- stall_cnt increments on each cycle with stall_all or a hazard freeze. flush_cnt increments on each br cycle. Both saturate at all-ones.
- A branch held during a stall is flushed on the first non-stalled cycle.

## Timing
- Reset (rst=0, asynchronous):
  - State RUN, wait_cnt=0, status_reg=0, mem_err=0, counters=0.
  - All combinational control outputs are forced to 0 while rst=0.
- Control outputs are combinational from inputs and state, with zero-cycle latency to pipeline register enables.
- status_reg is visible to the EXE instruction that follows the flag-setting one (1-cycle latency).
- Hazard bubble lasts 1 cycle with FWD_EN=1. With FWD_EN=0 it lasts until the producer leaves MEM (up to 2 cycles).
- TIMEOUT boundary: exactly TIMEOUT stalled cycles in MEM_WAIT. If mem_ready arrives in the cycle wait_cnt==TIMEOUT, completion wins and no error is raised.
- mem_ready while not in MEM_WAIT and mem_req=0 is ignored.

## Structure
- Shared package `arm_pkg`:
  - FSM state enum (RUN, MEM_WAIT, ERROR)
  - NZCV bit-index constants (N=3, Z=2, C=1, V=0)
  - register-index width constant (4)
- One sub-module `hazard_detect`, a purely combinational match logic parameterized by FWD_EN. Everything else stays in the top level.

## Test plan
- Load-use: EXE `LDR r3` (exe_mem_r_en=1, dest 3), ID reads r3, FWD_EN=1 → freeze_if=freeze_id=bubble_exe=1 for exactly 1 cycle, stall_cnt=1.
- Branch vs hazard in the same cycle: exe_branch_taken=1 plus a hazard → flush_if_id=1, bubble_exe=1, freezes 0, flush_cnt=1.
- Memory wait: mem_req=1 and mem_ready arriving after 3 cycles → stall_all high for 3 cycles, low in the ready cycle, FSM back in RUN. A branch held in EXE flushes the following cycle.
- Timeout: TIMEOUT=4, mem_ready never arrives → ERROR after 4 stalled cycles, mem_err=1 sticky, stall_all=1 until rst=0.
- Flags: exe_s=1, exe_status=4'b1010 → status_reg=1010 next cycle. The same update under stall_all=1 → status_reg unchanged.
- Async reset mid-MEM_WAIT: drop rst between clock edges → outputs 0 immediately, counters 0, RUN after release.
